// File: rtl/reg_arb_pkg.sv
// Shared types for the register write arbiter: FSM state encoding and
// the width of the committed-write counter.
package reg_arb_pkg;
   typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;
   localparam int CNT_W = 8;
endpackage

// File: rtl/shared_reg.sv
// WIDTH-bit storage flop with load enable and synchronous active-high clear.
module shared_reg #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   always_ff @(posedge clk) begin
      if (reset)     q <= '0;
      else if (load) q <= d;
   end
endmodule

// File: rtl/reg_write_arbiter.sv
// Arbitrates N requesters onto one shared register, one write per two cycles.
// Define RR_ARB_EN for round-robin arbitration; default is fixed lowest-index priority.
module reg_write_arbiter
   import reg_arb_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int N     = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N-1:0]         req,
   input  logic [N*WIDTH-1:0]   wr_data,
   output logic [N-1:0]         ack,
   output logic [WIDTH-1:0]     q,
   output logic                 busy,
   output logic [$clog2(N)-1:0] grant_id,
   output logic [CNT_W-1:0]     wr_count
);
   localparam int GW = $clog2(N);

   state_t         state, state_nxt;
   logic [GW-1:0]  winner;

`ifdef RR_ARB_EN
   // Search begins just past the previous winner so every requester gets a turn.
   function automatic logic [GW-1:0] pick_winner(input logic [N-1:0] r,
                                                 input logic [GW-1:0] last);
      logic [GW-1:0] w;
      int            idx;
      w = '0;
      for (int k = N; k >= 1; k--) begin
         idx = (int'(last) + k) % N;
         if (r[idx]) w = GW'(idx);
      end
      return w;
   endfunction

   assign winner = pick_winner(req, grant_id);
`else
   function automatic logic [GW-1:0] pick_winner(input logic [N-1:0] r);
      logic [GW-1:0] w;
      w = '0;
      for (int i = N - 1; i >= 0; i--)
         if (r[i]) w = GW'(i);
      return w;
   endfunction

   assign winner = pick_winner(req);
`endif

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (|req) state_nxt = WRITE;
         WRITE:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ack  = '0;
      busy = 1'b0;
      if (state == WRITE) begin
         ack[grant_id] = 1'b1;
         busy          = 1'b1;
      end
   end

   // grant_id also serves as the round-robin pointer; N-1 makes requester 0 first.
   always_ff @(posedge clk) begin
      if (reset)                     grant_id <= GW'(N - 1);
      else if (state == IDLE && |req) grant_id <= winner;
   end

   always_ff @(posedge clk) begin
      if (reset)               wr_count <= '0;
      else if (state == WRITE) wr_count <= wr_count + CNT_W'(1);
   end

   shared_reg #(.WIDTH(WIDTH)) u_reg (
      .clk   (clk),
      .reset (reset),
      .load  (state == WRITE),
      .d     (wr_data[grant_id*WIDTH +: WIDTH]),
      .q     (q)
   );
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter (N=4, WIDTH=4): vector table plus
// hand sequences, with an ack/q scoreboard running alongside.
module tb_reg_write_arbiter;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  req = '0;
   logic [15:0] wr_data = '0;
   logic [3:0]  ack;
   logic [3:0]  q;
   logic        busy;
   logic [1:0]  grant_id;
   logic [7:0]  wr_count;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [3:0]  req;
      logic [15:0] data;
      int          exp_fix;
      int          exp_rr;
   } vec_t;

   typedef struct {
      int         id;
      logic [3:0] data;
   } sb_t;

   vec_t       tbl[8];
   sb_t        sbq[$];
   logic [7:0] exp_cnt;
   logic       q_pending = 1'b0;
   logic [3:0] pend_data;

   reg_write_arbiter #(.WIDTH(4), .N(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .wr_data  (wr_data),
      .ack      (ack),
      .q        (q),
      .busy     (busy),
      .grant_id (grant_id),
      .wr_count (wr_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: each ack pops one expectation; q is checked one cycle later
   // unless reset was asserted in that WRITE cycle.
   always @(negedge clk) begin
      sb_t e;
      if (q_pending) begin
         check("sb_q", 32'(q), 32'(pend_data));
         q_pending = 1'b0;
      end
      if (ack !== 4'b0 && !$isunknown(ack)) begin
         if (sbq.size() == 0) begin
            check("sb_unexpected_ack", 32'(ack), 32'h0);
         end else begin
            e = sbq.pop_front();
            check("sb_ack", 32'(ack), 32'(4'b0001 << e.id));
            if (!reset) begin
               q_pending = 1'b1;
               pend_data = e.data;
            end
         end
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      req   = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      exp_cnt = '0;
   endtask

   // One write from IDLE; req is dropped in the WRITE cycle, data still commits.
   task automatic do_write(input logic [3:0] r, input logic [15:0] d, input int id);
      logic [3:0] exp_q;
      logic [3:0] onehot;
      sb_t        e;
      onehot = 4'b0001 << id;
      exp_q  = d[id*4 +: 4];
      req     = r;
      wr_data = d;
      e.id = id;
      e.data = exp_q;
      sbq.push_back(e);
      @(posedge clk); #1;
      check("wr_ack", 32'(ack), 32'(onehot));
      check("wr_busy", 32'(busy), 32'h1);
      check("wr_grant", 32'(grant_id), 32'(id));
      req = '0;
      @(posedge clk); #1;
      exp_cnt = exp_cnt + 8'd1;
      check("wr_count", 32'(wr_count), 32'(exp_cnt));
      check("wr_q", 32'(q), 32'(exp_q));
      check("wr_idle_ack", 32'(ack), 32'h0);
      check("wr_idle_busy", 32'(busy), 32'h0);
   endtask

   initial begin
      logic [3:0] last_q;
      int         exp_id;

      tbl[0] = '{4'b0010, 16'h00A0, 1, 1};
      tbl[1] = '{4'b1111, 16'h4321, 0, 2};
      tbl[2] = '{4'b1100, 16'h9876, 2, 3};
      tbl[3] = '{4'b1001, 16'hC0DB, 0, 0};
      tbl[4] = '{4'b0110, 16'h1E50, 1, 1};
      tbl[5] = '{4'b1000, 16'hF000, 3, 3};
      tbl[6] = '{4'b0101, 16'h0607, 0, 0};
      tbl[7] = '{4'b0101, 16'h0807, 0, 2};

      // Reset then idle
      do_reset();
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         check("idle_ack", 32'(ack), 32'h0);
         check("idle_q", 32'(q), 32'h0);
         check("idle_grant", 32'(grant_id), 32'h3);
         check("idle_count", 32'(wr_count), 32'h0);
         check("idle_busy", 32'(busy), 32'h0);
      end

      // Vector table
      for (int v = 0; v < 8; v++) begin
`ifdef RR_ARB_EN
         exp_id = tbl[v].exp_rr;
`else
         exp_id = tbl[v].exp_fix;
`endif
         do_write(tbl[v].req, tbl[v].data, exp_id);
      end

      // Sustained contention with req held: ack every second cycle
      do_reset();
      req     = 4'b1111;
      wr_data = 16'h4321;
      for (int k = 0; k < 5; k++) begin
         sb_t e;
`ifdef RR_ARB_EN
         e.id = k % 4;
`else
         e.id = 0;
`endif
         e.data = 4'(e.id + 1);
         sbq.push_back(e);
      end
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         check("contend_busy", 32'(busy), 32'((c % 2) == 0));
         if (c == 8) req = '0;
      end
      check("contend_count", 32'(wr_count), 32'd5);

      // Reset during WRITE aborts the commit
      do_reset();
      begin
         sb_t e;
         e.id = 0;
         e.data = 4'h5;
         sbq.push_back(e);
      end
      req     = 4'b0001;
      wr_data = 16'h0005;
      @(posedge clk); #1;
      check("mid_ack", 32'(ack), 32'h1);
      reset = 1'b1;
      req   = '0;
      @(posedge clk); #1;
      check("mid_q", 32'(q), 32'h0);
      check("mid_ack_after", 32'(ack), 32'h0);
      check("mid_busy", 32'(busy), 32'h0);
      check("mid_grant", 32'(grant_id), 32'h3);
      check("mid_count", 32'(wr_count), 32'h0);
      reset = 1'b0;
      @(posedge clk); #1;
      check("mid_idle_q", 32'(q), 32'h0);
      check("mid_idle_busy", 32'(busy), 32'h0);

      // 256 writes wrap the counter back to zero
      do_reset();
      last_q = '0;
      for (int i = 0; i < 256; i++) begin
         last_q = 4'(i * 7 + 3);
         do_write(4'b0001, {12'h0, last_q}, 0);
      end
      check("wrap_count", 32'(wr_count), 32'h0);
      check("wrap_q", 32'(q), 32'(last_q));

      @(posedge clk); #1;
      check("sb_drained", 32'(sbq.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the data width of the shared register.
REQ-002 The block SHALL have parameter N, default 4, giving the number of requesters (2..8).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 The block SHALL have port req, input, N bits: per-requester write request, level-held until ack.
REQ-006 The block SHALL have port wr_data, input, N*WIDTH bits: requester i's data in slice [i*WIDTH +: WIDTH].
REQ-007 The block SHALL have port ack, output, N bits: one-hot, one-cycle pulse marking the write commit for that requester.
REQ-008 The block SHALL have port q, output, WIDTH bits: current contents of the shared register.
REQ-009 The block SHALL have port busy, output, 1 bit: high while the FSM is in WRITE.
REQ-010 The block SHALL have port grant_id, output, $clog2(N) bits: index of the current or most recent winner.
REQ-011 The block SHALL have port wr_count, output, 8 bits: count of committed writes, wrapping.

Function
REQ-012 The FSM SHALL have exactly two states: IDLE and WRITE.
REQ-013 In IDLE with req==0, the FSM SHALL remain in IDLE and hold all outputs; ack SHALL be 0.
REQ-014 In IDLE with any req bit set, the block SHALL select one winner per the arbitration policy, register it into grant_id, and enter WRITE on the next edge.
REQ-015 In WRITE, ack[grant_id] SHALL be 1 for exactly that cycle, and busy SHALL be 1.
REQ-016 At the edge ending WRITE, q SHALL load wr_data slice grant_id, wr_count SHALL increment, and the FSM SHALL return to IDLE.
REQ-017 Sustained throughput SHALL be one write per 2 cycles; latency from req rising in IDLE to ack SHALL be 1 cycle, and to q updated SHALL be 2 cycles.
REQ-018 req changes during WRITE SHALL NOT abort the write: the data sampled in the WRITE cycle is committed even if the winner's req dropped.
REQ-019 Requests arriving during WRITE SHALL be considered only in the following IDLE cycle.
REQ-020 ack SHALL never have more than one bit set.
REQ-021 q SHALL change only at the end of a WRITE cycle or on reset.
REQ-022 wr_count SHALL wrap from 255 to 0 with no flag.

Reset
REQ-023 On reset, the block SHALL set: state IDLE, q=0, ack=0, busy=0, grant_id=N-1, wr_count=0.
REQ-024 Reset asserted during WRITE SHALL abort the write: q stays 0 and no ack is seen after the reset edge.
REQ-025 Reset SHALL take priority over every other event in the same cycle.

Configuration
REQ-026 When macro RR_ARB_EN is defined, arbitration SHALL be round-robin: the search starts at grant_id+1 modulo N, and the first set req wins.
REQ-027 When RR_ARB_EN is not defined, arbitration SHALL be fixed priority: the lowest set index wins, and grant_id is used only as an output.

Structure
REQ-028 A shared package reg_arb_pkg SHALL hold the state enum type (IDLE, WRITE) and the wr_count width constant (8).
REQ-029 The shared register SHALL be a sub-module shared_reg: a WIDTH-bit flop with load enable and synchronous active-high reset to 0.
REQ-030 Winner selection SHALL be a combinational function inside reg_write_arbiter; there SHALL be no separate module for it.

Verification (N=4, WIDTH=4)
REQ-031 Reset then idle: after reset, ack=0, q=0, grant_id=3 and wr_count=0 are observed for 10 cycles with req=0.
REQ-032 Single request: req=0010, wr_data slice1=0xA -> ack=0010 exactly 1 cycle later, q=0xA 2 cycles later, wr_count=1.
REQ-033 Contention with RR_ARB_EN: req=1111 held, slices 0x1/0x2/0x3/0x4 -> grant order 0,1,2,3,0, ack every 2nd cycle, q sequence 1,2,3,4,1.
REQ-034 Contention without RR_ARB_EN: req=1111 held -> requester 0 is granted every time; req=1100 -> requester 2 is granted.
REQ-035 Mid-write reset: req=0001 with data 0x5, reset asserted in the WRITE cycle -> q=0, ack=0 after the edge, FSM in IDLE.
REQ-036 Wrap: 256 single-requester writes -> wr_count returns to 0, q equals the last written value.
